bcd_formatter: RTL and testbench
================================

# bcd_formatter

Sequential binary-to-decimal formatter feeding the 8-digit 7-segment display driver. It accepts an unsigned binary value plus a decimal-point mask over a valid/ready handshake and converts the value iteratively with double-dabble. It presents registered per-digit `vld`, `digits` and `dots` vectors that connect directly to the display driver's inputs. Out-of-range values are shown as all-`E`.

## Interface

Parameters:
- `WIDTH`, default 32: input value width; legal range 4..32.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  request carries a new value.
- `in_ready`  out  1  block idle, able to accept a request.
- `in_value`  in  WIDTH  unsigned binary value.
- `in_dots`  in  8  decimal-point mask; bit i is the point on digit i.
- `vld`  out  8  digit i shown (1) or blank (0).
- `digits`  out  4 x [7:0]  unpacked array; `digits[i]` is the BCD code of decimal position i, where i=0 is least significant; code 4'hE means error.
- `dots`  out  8  registered copy of the accepted `in_dots`.
- `upd`  out  1  one-cycle pulse when the outputs change.

## Operation

- States:
  - IDLE: `in_ready`=1.
  - CONV: WIDTH cycles.
  - DONE: 1 cycle.
- IDLE→CONV on `in_valid & in_ready`.
  - Capture `in_value` into the shift register and `in_dots` into the dot holding register.
  - Clear the 40-bit BCD accumulator (10 digits).
- CONV, each cycle:
  - Add 3 to every BCD nibble that is ≥5.
  - Then shift {bcd, bin} left by 1.
  - After WIDTH cycles, go to DONE.
- DONE: update the output registers and pulse `upd`, then go to IDLE.
  - Overflow, i.e. BCD digit 8 or 9 nonzero: `digits[i]`=4'hE and `vld`=8'hFF for all i.
  - Otherwise `digits[i]` = BCD digit i, and `vld` is set per Configuration.
  - `dots` = captured mask, in both cases.
- `in_valid` outside IDLE is ignored. Nothing is queued and there is no back-pressure beyond `in_ready`=0.
- `in_value`/`in_dots` changing after acceptance have no effect.
- Outputs hold their last values between updates.

## Timing

- Reset values: `vld`=8'h00, all `digits`=4'h0, `dots`=8'h00, `upd`=0, state IDLE.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Latency: request accepted at edge E0; CONV occupies edges E1..E_WIDTH; outputs and `upd` are registered at edge E_{WIDTH+1}.
- `upd` is high for exactly that one cycle.
- `in_ready` is 0 from E0 until E_{WIDTH+1}. A new request can be accepted at E_{WIDTH+2} at the earliest.
  - Throughput is one value per WIDTH+2 cycles: 34 for WIDTH=32.
- `rst` during CONV/DONE aborts the conversion: outputs return to reset values, no `upd` pulse, state goes to IDLE.
- Values with WIDTH<32 are zero-extended. Overflow is possible only for WIDTH≥27.

## Configuration

Macro `BCD_FORMATTER_BLANK_EN`.

- Defined: leading-zero blanking.
  - `vld[i]`=1 for i=0.
  - `vld[i]`=1 for i>0 if any BCD digit j≥i is nonzero, or any `dots` bit j≥i is set.
  - A set point therefore forces its digit and all lower digits visible.
- Undefined: `vld`=8'hFF after every non-overflow update.
- Overflow behaviour is identical in both builds.

## Test plan

- Blank on: value 0, dots 8'h00 → `vld`=8'h01, `digits[0]`=0, `upd` exactly WIDTH+1 edges after acceptance.
- Blank on: value 1234 → `vld`=8'h0F, `digits[3:0]`=1,2,3,4, upper digits 0. Blank off: same value → `vld`=8'hFF.
- Value 99999999 → `vld`=8'hFF, all digits 9. Value 100000000 → all digits 4'hE, `vld`=8'hFF. Value 32'hFFFFFFFF → all digits E.
- Blank on: value 5, dots 8'h04 → `vld`=8'h07, `digits[2:0]`=0,0,5, `dots`=8'h04.
- `in_valid` held high with changing `in_value` during CONV → only the first value is displayed. Second acceptance occurs no earlier than E_{WIDTH+2}.
- `rst` pulsed at E10 of a conversion → `vld`=8'h00, no `upd`, `in_ready`=1 next cycle. A following value of 7 converts correctly.

Source files
------------

// File: rtl/bcd_formatter.sv
// bcd_formatter: sequential binary-to-decimal formatter for the 8-digit
// 7-segment display driver. Accepts a value and a decimal-point mask over
// in_valid/in_ready, converts with iterative double-dabble (one bit per cycle)
// and registers per-digit vld/digits/dots for the driver.
//
// Build option: define BCD_FORMATTER_BLANK_EN for leading-zero blanking;
// without it every non-overflow update shows all eight digits.
module bcd_formatter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [7:0]       in_dots,
  output logic [7:0]       vld,
  output logic [3:0]       digits [8],
  output logic [7:0]       dots,
  output logic             upd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] bin_reg;
  logic [39:0]      bcd_reg;
  logic [7:0]       dots_hold_reg;

  // Nibbles 0..8 get the add-3 correction. Nibble 9 can never reach 5 for a
  // 32-bit input (max 4294967295), so it is only shifted.
  logic [35:0]      bcd_adj;
  logic             accept;
  logic             last_shift;
  logic             overflow;
  logic [3:0]       dig_new [8];
  logic [7:0]       vld_new;
  logic [7:0]       lit;

  assign in_ready   = (state_reg == IDLE);
  assign accept     = in_valid & in_ready;
  assign last_shift = (cnt_reg == CW'(WIDTH - 1));
  assign overflow   = |bcd_reg[39:32];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
    for (gi = 0; gi < 8; gi++) begin : g_dig
      assign dig_new[gi] = overflow ? 4'hE : bcd_reg[gi*4 +: 4];
      // Digit gi is lit if it or any more significant digit is nonzero, or a
      // point at or above it is set.
      assign lit[gi] = (|bcd_reg[31:gi*4]) | (|dots_hold_reg[7:gi]);
    end
  endgenerate

`ifdef BCD_FORMATTER_BLANK_EN
  assign vld_new = overflow ? 8'hFF : {lit[7:1], 1'b1};
`else
  assign vld_new = 8'hFF;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: IDLE -> CONV for WIDTH cycles -> DONE for one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CONV;
      CONV:    if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath: capture on accept, then correct-and-shift each CONV cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      bin_reg       <= '0;
      bcd_reg       <= '0;
      dots_hold_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg       <= '0;
            bin_reg       <= in_value;
            bcd_reg       <= '0;
            dots_hold_reg <= in_dots;
          end
        end
        CONV: begin
          bcd_reg <= {bcd_reg[38:36], bcd_adj, bin_reg[WIDTH-1]};
          bin_reg <= bin_reg << 1;
          cnt_reg <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output registers: loaded once in DONE together with the upd pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 8'h00;
      dots <= 8'h00;
      upd  <= 1'b0;
      for (int i = 0; i < 8; i++) digits[i] <= 4'h0;
    end else begin
      upd <= 1'b0;
      if (state_reg == DONE) begin
        upd  <= 1'b1;
        vld  <= vld_new;
        dots <= dots_hold_reg;
        for (int i = 0; i < 8; i++) digits[i] <= dig_new[i];
      end
    end
  end

endmodule

// File: tb/tb_bcd_formatter.sv
// Self-checking bench for bcd_formatter: directed and random conversions
// compared against a decimal-arithmetic reference model.
module tb_bcd_formatter;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = '0;
  logic [7:0]  in_dots = '0;
  logic [7:0]  vld;
  logic [3:0]  digits [8];
  logic [7:0]  dots;
  logic        upd;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_formatter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_dots(in_dots), .vld(vld), .digits(digits),
    .dots(dots), .upd(upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dig_vec();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = digits[i];
    return r;
  endfunction

  // Reference: decimal digits by division; blanking from magnitude and points.
  task automatic model(input logic [31:0] v, input logic [7:0] d,
                       output logic [31:0] e_dig, output logic [7:0] e_vld);
    longint unsigned p = 1;
    longint unsigned lv = longint'(v);
    if (lv >= 64'd100000000) begin
      e_dig = 32'hEEEEEEEE;
      e_vld = 8'hFF;
    end else begin
      for (int i = 0; i < 8; i++) begin
        e_dig[i*4 +: 4] = 4'((lv / p) % 10);
`ifdef BCD_FORMATTER_BLANK_EN
        e_vld[i] = (i == 0) || (lv >= p) || ((d >> i) != 8'h00);
`else
        e_vld[i] = 1'b1;
`endif
        p = p * 10;
      end
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] v, input logic [7:0] d);
    logic [31:0] e_dig;
    logic [7:0]  e_vld;
    model(v, d, e_dig, e_vld);
    $display("conv %s: value=%0d dots=%02h -> digits=%08h vld=%02h", tag, v, d, dig_vec(), vld);
    check({tag, "_digits"}, dig_vec(), e_dig);
    check({tag, "_vld"}, {24'h0, vld}, {24'h0, e_vld});
    check({tag, "_dots"}, {24'h0, dots}, {24'h0, d});
  endtask

  // Sample after each edge until upd is seen or the budget runs out.
  task automatic wait_upd(output int n);
    n = 0;
    while (upd !== 1'b1 && n < WIDTH + 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_conv(input string tag, input logic [31:0] v, input logic [7:0] d);
    int n;
    @(negedge clk);
    check({tag, "_ready"}, {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; in_value = v; in_dots = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_value = $urandom; in_dots = 8'($urandom);
    wait_upd(n);
    check({tag, "_latency"}, n, WIDTH + 1);
    check_out(tag, v, d);
  endtask

  initial begin
    int n, ready_hi, upd_cnt;
    logic [31:0] v, a, b;
    logic [7:0]  d, da, db;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    check("rst_vld", {24'h0, vld}, 32'h0);
    check("rst_digits", dig_vec(), 32'h0);
    check("rst_dots", {24'h0, dots}, 32'h0);
    check("rst_upd", {31'h0, upd}, 32'h0);

    // Directed values and boundaries.
    do_conv("zero", 32'd0, 8'h00);
    do_conv("v1234", 32'd1234, 8'h00);
    do_conv("max_ok", 32'd99999999, 8'h00);
    do_conv("ovf_lo", 32'd100000000, 8'h5A);
    do_conv("ovf_max", 32'hFFFFFFFF, 8'h00);
    do_conv("dot5", 32'd5, 8'h04);
    do_conv("dot_top", 32'd42, 8'h80);

    // Upd lasts exactly one cycle.
    @(posedge clk); #1;
    check("upd_one_cycle", {31'h0, upd}, 32'h0);

    // Random values of mixed magnitude.
    for (int k = 0; k < 12; k++) begin
      case (k % 4)
        0: v = $urandom % 10000;
        1: v = $urandom % 100000000;
        2: v = $urandom;
        default: v = 32'd1 << ($urandom % 32);
      endcase
      d = ((k % 3) == 0) ? 8'h00 : 8'($urandom);
      do_conv($sformatf("rnd%0d", k), v, d);
    end

    // in_valid held high with changing inputs: only the first value is taken.
    a = 32'd8675309; da = 8'h10;
    b = 32'd271828;  db = 8'h02;
    @(negedge clk);
    in_valid = 1'b1; in_value = a; in_dots = da;
    @(posedge clk); #1;
    check("hold_busy", {31'h0, in_ready}, 32'h0);
    n = 0; ready_hi = 0;
    while (upd !== 1'b1 && n < WIDTH + 10) begin
      in_value = $urandom; in_dots = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (in_ready === 1'b1 && upd !== 1'b1) ready_hi++;
    end
    check("hold_latency", n, WIDTH + 1);
    check("hold_ready_low", ready_hi, 0);
    check_out("hold_first", a, da);
    check("hold_ready_after", {31'h0, in_ready}, 32'h1);
    in_value = b; in_dots = db;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_second_taken", {31'h0, in_ready}, 32'h0);
    wait_upd(n);
    check("hold2_latency", n, WIDTH + 1);
    check_out("hold_second", b, db);

    // Reset at E10 aborts the conversion.
    @(negedge clk);
    in_valid = 1'b1; in_value = 32'd12345678; in_dots = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_vld", {24'h0, vld}, 32'h0);
    check("abort_digits", dig_vec(), 32'h0);
    check("abort_dots", {24'h0, dots}, 32'h0);
    check("abort_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk); rst = 1'b0;
    upd_cnt = 0;
    for (int k = 0; k < WIDTH + 5; k++) begin
      @(posedge clk); #1;
      if (upd === 1'b1) upd_cnt++;
    end
    check("abort_no_upd", upd_cnt, 0);
    do_conv("after_abort", 32'd7, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
